mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus cycles without bus_ack before abort (only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-004 SHALL have ports: if_req in 1, if_addr in 32, if_rdata out 32, if_ready out 1 (fetch port, word read only).
REQ-005 SHALL have ports: mem_req in 1, mem_we in 1, mem_sel in 4, mem_addr in 32, mem_wdata in 32, mem_rdata out 32, mem_ready out 1 (data port).
REQ-006 SHALL have ports: bus_req out 1, bus_we out 1, bus_sel out 4, bus_addr out 32, bus_wdata out 32, bus_rdata in 32, bus_ack in 1 (single shared memory port).
REQ-007 SHALL have ports: stall_request out 1 (to pipeline control), timeout_error out 1 (sticky).

Function
REQ-008 SHALL implement FSM states IDLE, IF_BUSY, MEM_BUSY, DONE.
REQ-009 IDLE: mem_req=1 -> MEM_BUSY; else if_req=1 -> IF_BUSY; else stay; mem has fixed priority over if.
REQ-010 On IDLE->BUSY edge SHALL register requester fields onto bus_*; IF grant drives bus_we=0, bus_sel=4'b1111, bus_wdata=0.
REQ-011 bus_req SHALL be 1 exactly while in IF_BUSY or MEM_BUSY; bus_* fields stable throughout.
REQ-012 In BUSY, bus_ack=1 SHALL capture bus_rdata into owner's rdata (0 for writes), move to DONE.
REQ-013 DONE SHALL last one cycle, pulse owner's ready for that cycle only, ignore all req inputs, return to IDLE.
REQ-014 Requester SHALL hold req and fields stable until its ready cycle; latency from grant = 1 + bus wait + 1 cycles, minimum 3 cycles req-to-ready.
REQ-015 if_rdata/mem_rdata SHALL hold last value until next completion on same port.
REQ-016 bus_ack in IDLE or DONE SHALL be ignored.
REQ-017 stall_request SHALL be combinational: (if_req & ~if_ready) | (mem_req & ~mem_ready).
REQ-018 Simultaneous if_req and mem_req in IDLE: mem served first; if served after following DONE if still requested.
REQ-019 Req dropped while BUSY SHALL not abort the bus transaction; completion still pulses ready.

Reset
REQ-020 Reset assertion SHALL immediately force IDLE, bus_req=0, all bus_* fields 0, if_rdata=mem_rdata=0, both ready=0, timeout_error=0.
REQ-021 Reset mid-transaction SHALL abandon it; no ready pulse SHALL follow deassertion.
REQ-022 First grant possible on the first clock edge after reset deasserts.

Configuration
REQ-023 With MEM_ARB_TIMEOUT_EN defined: 8-bit cycle counter cleared on BUSY entry; reaching TIMEOUT_CYCLES without bus_ack -> DONE with owner rdata=0, ready pulsed, timeout_error set until reset.
REQ-024 Without MEM_ARB_TIMEOUT_EN: no counter, BUSY waits indefinitely, timeout_error tied 0.

Structure
REQ-025 FSM state encodings and port-id constants SHALL live in the shared defines header with other OP_/CATEGORY_ constants.
REQ-026 Timeout counter SHALL be sub-module mem_arb_watchdog (start, ack, expire), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-027 if_req=1, if_addr=0x00000040, bus_ack one cycle after bus_req with bus_rdata=0x3C010001 -> if_ready pulses once, if_rdata=0x3C010001, bus_we=0, bus_sel=1111.
REQ-028 if_req and mem_req (mem_we=1, mem_sel=0001, addr 0x100, wdata 0xAB) same cycle -> write granted first, mem_ready then if_ready, stall_request high until if_ready.
REQ-029 bus_ack held low 10 cycles on mem read -> bus_req stays 1, fields stable, stall_request=1, mem_ready after ack only.
REQ-030 Reset asserted mid MEM_BUSY -> bus_req=0 without clock edge, no mem_ready after release, rdata=0.
REQ-031 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> after 4 BUSY cycles ready pulses, rdata=0, timeout_error=1 until reset.
REQ-032 Stray bus_ack in IDLE -> no ready pulse, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_pkg : shared FSM encodings, port ids and opcode constants
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  localparam logic       PORT_IF           = 1'b0;
  localparam logic       PORT_MEM          = 1'b1;
  localparam logic       OP_READ           = 1'b0;
  localparam logic       OP_WRITE          = 1'b1;
  localparam logic [3:0] CATEGORY_WORD_SEL = 4'b1111;
  localparam int unsigned WD_WIDTH         = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arb_watchdog : saturating bus-wait counter, expire after TIMEOUT_CYCLES
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic expire
);

  localparam logic [WD_WIDTH-1:0] c_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [WD_WIDTH-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (start || ack) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q holds the number of completed wait cycles, so the last one flags
  assign expire = (count_q == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : fetch/data port arbiter onto one shared memory bus
// Optional bus timeout with MEM_ARB_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_request,
  output logic        timeout_error
);

  arb_state_e  state_q;
  logic        owner_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        timeout_error_q;
  logic [31:0] rdata_d;
  logic        w_expire;

  // Writes and timeouts both complete with zero read data
  assign rdata_d = (bus_ack && bus_we_q == OP_READ) ? bus_rdata : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_grant;
  logic w_wd_expire;

  assign w_grant = (state_q == ST_IDLE) && (mem_req || if_req);

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock (clock),
    .reset (reset),
    .start (w_grant),
    .ack   (bus_ack),
    .expire(w_wd_expire)
  );

  assign w_expire = w_wd_expire;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign w_expire     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= PORT_IF;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_sel_q       <= '0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      if_rdata_q      <= '0;
      mem_rdata_q     <= '0;
      if_ready_q      <= 1'b0;
      mem_ready_q     <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            state_q     <= ST_MEM_BUSY;
            owner_q     <= PORT_MEM;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_we;
            bus_sel_q   <= mem_sel;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
          end else if (if_req) begin
            state_q     <= ST_IF_BUSY;
            owner_q     <= PORT_IF;
            bus_req_q   <= 1'b1;
            bus_we_q    <= OP_READ;
            bus_sel_q   <= CATEGORY_WORD_SEL;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
          end
        end
        ST_IF_BUSY, ST_MEM_BUSY: begin
          // A real acknowledge takes precedence over a coincident timeout
          if (bus_ack || w_expire) begin
            state_q   <= ST_DONE;
            bus_req_q <= 1'b0;
            if (owner_q == PORT_MEM) begin
              mem_rdata_q <= rdata_d;
              mem_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= rdata_d;
              if_ready_q <= 1'b1;
            end
            if (!bus_ack) begin
              timeout_error_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_sel       = bus_sel_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign mem_rdata     = mem_rdata_q;
  assign if_ready      = if_ready_q;
  assign mem_ready     = mem_ready_q;
  assign timeout_error = timeout_error_q;
  assign stall_request = (if_req & ~if_ready_q) | (mem_req & ~mem_ready_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : directed scenarios plus randomized traffic vs a
// transaction-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stall_request;
  logic        timeout_error;

  always #5 clock = ~clock;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_request(stall_request), .timeout_error(timeout_error)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction record, completion slot
  bit          m_busy;
  bit          m_port;      // 0 fetch, 1 data
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  int          m_wait;
  int          m_done;      // -1 none, else port completing this cycle
  logic [31:0] m_if_rdata, m_mem_rdata;
  bit          m_terr;

  task automatic model_clear();
    m_busy = 0; m_port = 0; m_we = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
    m_wait = 0; m_done = -1; m_if_rdata = '0; m_mem_rdata = '0; m_terr = 0;
  endtask

  task automatic model_step();
    logic [31:0] d;
    if (m_done >= 0) begin
      m_done = -1;
    end else if (m_busy) begin
      m_wait++;
      if (bus_ack || (TO_EN && m_wait >= TMO)) begin
        d = (bus_ack && !m_we) ? bus_rdata : 32'h0;
        if (m_port) m_mem_rdata = d;
        else        m_if_rdata  = d;
        if (!bus_ack) m_terr = 1;
        m_busy = 0;
        m_done = m_port ? 1 : 0;
      end
    end else if (mem_req) begin
      m_busy = 1; m_port = 1; m_we = mem_we; m_sel = mem_sel;
      m_addr = mem_addr; m_wdata = mem_wdata; m_wait = 0;
    end else if (if_req) begin
      m_busy = 1; m_port = 0; m_we = 0; m_sel = 4'hF;
      m_addr = if_addr; m_wdata = '0; m_wait = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clock);
      if (reset) model_clear();
      chk("bus_req", bus_req, m_busy);
      if (m_busy || reset) begin
        chk("bus_we", bus_we, m_we);
        chk("bus_sel", bus_sel, m_sel);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_wdata", bus_wdata, m_wdata);
      end
      chk("if_ready", if_ready, m_done == 0);
      chk("mem_ready", mem_ready, m_done == 1);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      chk("stall", stall_request,
          (if_req & (m_done != 0)) | (mem_req & (m_done != 1)));
      chk("timeout_error", timeout_error, m_terr);
      if (!reset) model_step();
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int mr, ir;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_ready", {if_ready, mem_ready}, 0);
    chk("rst_rdata", if_rdata | mem_rdata, 0);
    chk("rst_terr", timeout_error, 0);

    // Fetch read, grant on first edge after reset release, ack one cycle later
    reset = 0; if_req = 1; if_addr = 32'h40;
    step();
    chk("r27_bus_req", bus_req, 1);
    chk("r27_bus_we", bus_we, 0);
    chk("r27_bus_sel", bus_sel, 4'hF);
    chk("r27_bus_addr", bus_addr, 32'h40);
    bus_ack = 1; bus_rdata = 32'h3C010001;
    step();
    chk("r27_if_ready", if_ready, 1);
    chk("r27_if_rdata", if_rdata, 32'h3C010001);
    chk("r27_model_rdata", m_if_rdata, 32'h3C010001);
    bus_ack = 0; if_req = 0;
    step();
    chk("r27_ready_once", if_ready, 0);

    // Stray acknowledge while idle
    bus_ack = 1; bus_rdata = 32'h12345678;
    repeat (3) begin
      step();
      chk("r32_bus_req", bus_req, 0);
      chk("r32_ready", {if_ready, mem_ready}, 0);
      chk("r32_if_rdata", if_rdata, 32'h3C010001);
    end
    bus_ack = 0;

    // Simultaneous requests: data write first, then fetch
    mem_req = 1; mem_we = 1; mem_sel = 4'b0001; mem_addr = 32'h100; mem_wdata = 32'hAB;
    if_req = 1; if_addr = 32'h200; bus_rdata = 32'h0BADF00D;
    mr = -1; ir = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) begin
        chk("r28_bus_we", bus_we, 1);
        chk("r28_bus_sel", bus_sel, 4'b0001);
        chk("r28_bus_addr", bus_addr, 32'h100);
        chk("r28_bus_wdata", bus_wdata, 32'hAB);
      end
      if (mem_ready && mr < 0) begin mr = i; mem_req = 0; end
      if (if_ready && ir < 0) begin
        ir = i; if_req = 0;
      end else if (ir < 0) begin
        chk("r28_stall", stall_request, 1);
      end
      bus_ack = bus_req;
    end
    bus_ack = 0;
    chk("r28_mem_ready_cycle", mr, 2);
    chk("r28_if_ready_cycle", ir, 5);
    chk("r28_mem_rdata", mem_rdata, 0);
    chk("r28_if_rdata", if_rdata, 32'h0BADF00D);

`ifdef MEM_ARB_TIMEOUT_EN
    // No acknowledge: abort after TMO busy cycles
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h300; mem_wdata = 32'h55;
    mr = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (mem_ready && mr < 0) begin mr = i; mem_req = 0; end
    end
    chk("r31_ready_cycle", mr, 5);
    chk("r31_mem_rdata", mem_rdata, 0);
    chk("r31_terr_sticky", timeout_error, 1);
`else
    // Long bus wait on a data read
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h300; mem_wdata = 32'h55;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("r29_bus_req", bus_req, 1);
      chk("r29_bus_addr", bus_addr, 32'h300);
      chk("r29_bus_we", bus_we, 0);
      chk("r29_stall", stall_request, 1);
      chk("r29_mem_ready", mem_ready, 0);
      step();
    end
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    step();
    chk("r29_mem_ready_ack", mem_ready, 1);
    chk("r29_mem_rdata", mem_rdata, 32'hDEADBEEF);
    bus_ack = 0; mem_req = 0;
    step();
`endif

    // Reset in the middle of a data transaction
    mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    step(); step();
    chk("r30_busy", bus_req, 1);
    #2 reset = 1;
    #1;
    chk("r30_async_bus_req", bus_req, 0);
    chk("r30_bus_addr", bus_addr, 0);
    chk("r30_mem_rdata", mem_rdata, 0);
    chk("r30_terr", timeout_error, 0);
    mem_req = 0;
    @(posedge clock);
    #1 reset = 0;
    repeat (4) begin
      step();
      chk("r30_no_ready", mem_ready, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 997 == 500) begin
        #2 reset = 1;
        @(posedge clock);
        #1 reset = 0;
      end
      if (mem_ready) mem_req = 0;
      else if (mem_req && $urandom_range(0, 49) == 0) mem_req = 0;
      else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_we = 1'($urandom); mem_sel = 4'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      if (if_ready) if_req = 0;
      else if (if_req && $urandom_range(0, 49) == 0) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      bus_ack = ($urandom_range(0, 99) < 35);
      bus_rdata = $urandom;
      step();
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
